// File: rtl/gic_target.sv
// Responder end of the 4-bit GIC nibble link: collects command/address/data nibbles,
// runs one 32-bit req/ack back-end access and returns a status nibble plus read data.
module gic_target #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [3:0]  STATUS_OK      = 4'hA,
  parameter logic [3:0]  STATUS_ERR     = 4'hE
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        gic_cs_i,
  input  logic [3:0]  gic_dat_i,
  output logic [3:0]  gic_dat_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_STATUS,
    S_RDATA,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [31:0] r_rdata;
  logic [31:0] r_cnt;
  logic [2:0]  r_nib;
  logic        r_we;
  logic        r_err;
  logic        r_req;
  logic [3:0]  r_dat_o;
  logic [3:0]  w_dat_next;
  logic        w_cmd_ok;
  logic        w_last_nib;
  logic        w_tmo;
  logic        w_in_bus;
  logic        w_term;
  logic        w_enter_bus;
  logic [3:0]  w_rd_nib [8];

  // Read data nibble lanes, index 0 is the most significant nibble.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rd_nib
    assign w_rd_nib[gi] = r_rdata[31-4*gi -: 4];
  end

  assign w_cmd_ok    = (gic_dat_i[2:0] == 3'b000);
  assign w_last_nib  = (r_nib == 3'd7);
  assign w_tmo       = (TMO_LIMIT != 32'd0) && (r_cnt == TMO_LIMIT - 32'd1);
  assign w_in_bus    = (r_state == S_BUS) || (r_state == S_DRAIN);
  assign w_term      = w_in_bus && (bus_ack_i || bus_err_i || w_tmo);
  assign w_enter_bus = (w_state_next == S_BUS) && (r_state != S_BUS);

  assign gic_dat_o = r_dat_o;
  assign bus_req_o = r_req;
  assign bus_we_o  = r_we;
  assign bus_adr_o = r_adr;
  assign bus_dat_o = r_wdat;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dat_next   = 4'h0;
    case (r_state)
      S_IDLE: begin
        if (gic_cs_i) begin
          w_state_next = w_cmd_ok ? S_ADDR : S_STATUS;
        end
      end
      S_ADDR: begin
        if (!gic_cs_i) begin
          w_state_next = S_IDLE;
        end else if (w_last_nib) begin
          w_state_next = r_we ? S_WDATA : S_BUS;
        end
      end
      S_WDATA: begin
        if (!gic_cs_i) begin
          w_state_next = S_IDLE;
        end else if (w_last_nib) begin
          w_state_next = S_BUS;
        end
      end
      S_BUS: begin
        if (w_term) begin
          w_state_next = gic_cs_i ? S_STATUS : S_IDLE;
        end else if (!gic_cs_i) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_term) begin
          w_state_next = S_IDLE;
        end
      end
      S_STATUS: begin
        w_dat_next = r_err ? STATUS_ERR : STATUS_OK;
        if (!gic_cs_i) begin
          w_state_next = S_IDLE;
        end else if (!r_err && !r_we) begin
          w_state_next = S_RDATA;
        end else begin
          w_state_next = S_DONE;
        end
      end
      S_RDATA: begin
        w_dat_next = w_rd_nib[r_nib];
        if (!gic_cs_i) begin
          w_state_next = S_IDLE;
        end else if (w_last_nib) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!gic_cs_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      r_adr   <= 32'd0;
      r_wdat  <= 32'd0;
      r_rdata <= 32'd0;
      r_cnt   <= 32'd0;
      r_nib   <= 3'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_dat_o <= 4'h0;
    end else begin
      r_dat_o <= w_dat_next;

      if (w_enter_bus) begin
        r_req <= 1'b1;
        r_cnt <= 32'd0;
      end else if (w_in_bus) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_term) begin
        r_req <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_nib <= 3'd0;
          if (gic_cs_i) begin
            r_err <= !w_cmd_ok;
            if (w_cmd_ok) begin
              r_we <= gic_dat_i[3];
            end
          end
        end
        S_ADDR: begin
          if (gic_cs_i) begin
            r_adr <= {r_adr[27:0], gic_dat_i};
            r_nib <= r_nib + 3'd1;
          end
        end
        S_WDATA: begin
          if (gic_cs_i) begin
            r_wdat <= {r_wdat[27:0], gic_dat_i};
            r_nib  <= r_nib + 3'd1;
          end
        end
        S_BUS: begin
          // Error has priority over ack; a timeout is any termination without ack.
          if (w_term) begin
            r_err <= bus_err_i || !bus_ack_i;
            if (bus_ack_i && !bus_err_i) begin
              r_rdata <= bus_dat_i;
            end
          end
        end
        S_STATUS: begin
          r_nib <= 3'd0;
        end
        S_RDATA: begin
          r_nib <= r_nib + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gic_target.sv
// Scoreboard bench for gic_target: stimulus queues expected link responses and
// back-end transfers, two monitors pop and compare as the DUT produces them.
module tb_gic_target;

  typedef struct {
    logic [3:0]  st;
    logic        hd;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic [3:0]  dat;
  logic        nt_en;
  logic        force_ack;
  logic        be_ack;
  logic        be_err;
  logic        be_ack_en;
  logic        be_err_en;
  logic [31:0] be_rdata;
  int          be_delay;
  int          be_cnt;
  logic        w_ack;
  logic        w_cs_nt;

  logic [3:0]  gdo;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  gdo_nt;
  logic        req_nt;
  logic        we_nt;
  logic [31:0] adr_nt;
  logic [31:0] wdat_nt;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   c0;
  logic mon_en = 1'b0;
  rsp_t rsp_q[$];
  bus_t bus_q[$];
  rsp_t mon_cur;
  int   mon_left = 0;
  bus_t bmon_cur;
  logic bmon_active = 1'b0;
  logic bmon_prev = 1'b0;
  int   bmon_len = 0;

  assign w_ack   = be_ack | force_ack;
  assign w_cs_nt = cs & nt_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gic_target #(.TIMEOUT_CYCLES(4)) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .gic_cs_i    (cs),
    .gic_dat_i   (dat),
    .gic_dat_o   (gdo),
    .bus_req_o   (req),
    .bus_we_o    (we),
    .bus_adr_o   (adr),
    .bus_dat_o   (wdat),
    .bus_dat_i   (be_rdata),
    .bus_ack_i   (w_ack),
    .bus_err_i   (be_err)
  );

  gic_target #(.TIMEOUT_CYCLES(0)) dut_nt (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .gic_cs_i    (w_cs_nt),
    .gic_dat_i   (dat),
    .gic_dat_o   (gdo_nt),
    .bus_req_o   (req_nt),
    .bus_we_o    (we_nt),
    .bus_adr_o   (adr_nt),
    .bus_dat_o   (wdat_nt),
    .bus_dat_i   (be_rdata),
    .bus_ack_i   (w_ack),
    .bus_err_i   (be_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_rsp(input logic [3:0] st, input logic hd, input logic [31:0] d, input int c);
    rsp_t r;
    r.st = st; r.hd = hd; r.data = d; r.cyc = c;
    rsp_q.push_back(r);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic w, input int len);
    bus_t b;
    b.adr = a; b.dat = d; b.we = w; b.len = len;
    bus_q.push_back(b);
  endtask

  // Keeps cs high for 'hold' cycles, driving the first n nibbles of vec (MSB first).
  task automatic frame(input logic [67:0] vec, input int n, input int hold);
    for (int k = 0; k < hold; k++) begin
      cs  = 1'b1;
      dat = (k < n) ? vec[4*(n-1-k) +: 4] : 4'h0;
      @(negedge clk);
    end
    cs  = 1'b0;
    dat = 4'h0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Back-end responder: terminates on the be_delay-th cycle of an active request.
  initial begin
    be_ack = 1'b0;
    be_err = 1'b0;
    be_cnt = 0;
    forever begin
      @(negedge clk);
      if (req === 1'b1) begin
        be_cnt++;
        be_ack = be_ack_en && (be_cnt == be_delay);
        be_err = be_err_en && (be_cnt == be_delay);
      end else begin
        be_cnt = 0;
        be_ack = 1'b0;
        be_err = 1'b0;
      end
    end
  end

  // Link monitor: any nonzero nibble starts a response that must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mon_left > 0) begin
          chk("rdata_nibble", 32'(gdo), 32'(mon_cur.data[4*mon_left-1 -: 4]));
          mon_left--;
        end else if (gdo !== 4'h0) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_nibble", 32'(gdo), 32'd0);
          end else begin
            mon_cur = rsp_q.pop_front();
            chk("status", 32'(gdo), 32'(mon_cur.st));
            chk("status_cycle", cyc, mon_cur.cyc);
            $display("rsp: status=%h cycle=%0d data=%h", gdo, cyc, mon_cur.data);
            if (mon_cur.hd) mon_left = 8;
          end
        end
      end
    end
  end

  // Back-end monitor: checks address/direction/data on request rise and its length on fall.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (req === 1'b1 && !bmon_prev) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_req", 32'(req), 32'd0);
            bmon_active = 1'b0;
          end else begin
            bmon_cur = bus_q.pop_front();
            chk("bus_adr", adr, bmon_cur.adr);
            chk("bus_we", 32'(we), 32'(bmon_cur.we));
            if (bmon_cur.we) chk("bus_wdat", wdat, bmon_cur.dat);
            bmon_active = 1'b1;
            bmon_len = 1;
          end
        end else if (req === 1'b1) begin
          bmon_len++;
        end else if (bmon_prev && bmon_active) begin
          chk("req_cycles", bmon_len, bmon_cur.len);
          $display("bus: adr=%h we=%0d req_cycles=%0d", bmon_cur.adr, bmon_cur.we, bmon_len);
          bmon_active = 1'b0;
        end
        bmon_prev = (req === 1'b1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs = 1'b0; dat = 4'h0; nt_en = 1'b0; force_ack = 1'b0;
    be_ack_en = 1'b0; be_err_en = 1'b0; be_delay = 0; be_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_gic_dat", 32'(gdo), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_wdat", wdat, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    gap(2);

    // Write, ack on 3rd request cycle: status at cmd + 18 + 3.
    be_ack_en = 1'b1; be_err_en = 1'b0; be_delay = 3;
    c0 = cyc;
    push_rsp(4'hA, 1'b0, 32'd0, c0 + 21);
    push_bus(32'h12345678, 32'hDEADBEEF, 1'b1, 3);
    frame(68'h8_12345678_DEADBEEF, 17, 30);
    gap(3);

    // Read, ack on 2nd cycle: status at cmd + 10 + 2 then 8 data nibbles.
    be_delay = 2; be_rdata = 32'hCAFEF00D;
    c0 = cyc;
    push_rsp(4'hA, 1'b1, 32'hCAFEF00D, c0 + 12);
    push_bus(32'h00001000, 32'd0, 1'b0, 2);
    frame(68'h0_00001000, 9, 30);
    gap(3);

    // Read terminated by error on the 1st cycle.
    be_ack_en = 1'b0; be_err_en = 1'b1; be_delay = 1;
    c0 = cyc;
    push_rsp(4'hE, 1'b0, 32'd0, c0 + 11);
    push_bus(32'h89ABCDEF, 32'd0, 1'b0, 1);
    frame(68'h0_89ABCDEF, 9, 25);
    gap(3);

    // Ack and error together: error wins.
    be_ack_en = 1'b1; be_err_en = 1'b1; be_delay = 2;
    c0 = cyc;
    push_rsp(4'hE, 1'b0, 32'd0, c0 + 12);
    push_bus(32'h76543210, 32'd0, 1'b0, 2);
    frame(68'h0_76543210, 9, 25);
    gap(3);

    // No termination: 4-cycle timeout on dut, dut_nt holds its request until a late ack.
    be_ack_en = 1'b0; be_err_en = 1'b0; be_rdata = 32'h0F1E2D3C;
    nt_en = 1'b1;
    c0 = cyc;
    push_rsp(4'hE, 1'b0, 32'd0, c0 + 14);
    push_bus(32'h00001000, 32'd0, 1'b0, 4);
    fork
      frame(68'h0_00001000, 9, 50);
      begin
        repeat (30) @(negedge clk);
        chk("nt_req_held", 32'(req_nt), 32'd1);
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        chk("nt_req_released", 32'(req_nt), 32'd0);
        chk("nt_status", 32'(gdo_nt), 32'hA);
        chk("nt_adr", adr_nt, 32'h00001000);
      end
    join
    nt_en = 1'b0;
    gap(3);

    // Bad command nibble: error status, no request.
    c0 = cyc;
    push_rsp(4'hE, 1'b0, 32'd0, c0 + 2);
    frame(68'h9, 1, 8);
    gap(3);

    // cs drops after 3 address nibbles: nothing happens.
    frame(68'h0_123, 4, 4);
    gap(3);

    // cs drops in the 2nd request cycle: transfer drains on late ack, nothing returned.
    be_ack_en = 1'b1; be_err_en = 1'b0; be_delay = 3;
    push_bus(32'h0000ABCD, 32'd0, 1'b0, 3);
    frame(68'h0_0000ABCD, 9, 10);
    gap(6);

    // Next frame is accepted normally.
    be_delay = 1;
    c0 = cyc;
    push_rsp(4'hA, 1'b0, 32'd0, c0 + 19);
    push_bus(32'hFFFFFFF0, 32'h0000000F, 1'b1, 1);
    frame(68'h8_FFFFFFF0_0000000F, 17, 30);
    gap(3);

    // Reset in the 2nd request cycle drops the request and clears the registers.
    be_ack_en = 1'b0;
    push_bus(32'h00002000, 32'd0, 1'b0, 2);
    frame(68'h0_00002000, 9, 10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_bus_req", 32'(req), 32'd0);
    chk("rst_bus_adr", adr, 32'd0);
    chk("rst_bus_gic_dat", 32'(gdo), 32'd0);
    gap(4);

    // Recovery after reset: read acked on the 1st cycle.
    be_ack_en = 1'b1; be_delay = 1; be_rdata = 32'h0F1E2D3C;
    c0 = cyc;
    push_rsp(4'hA, 1'b1, 32'h0F1E2D3C, c0 + 11);
    push_bus(32'h00000004, 32'd0, 1'b0, 1);
    frame(68'h0_00000004, 9, 25);
    gap(5);

    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("bus_queue_drained", bus_q.size(), 32'd0);
    chk("rdata_nibbles_drained", mon_left, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
